// File: rtl/packet_handler_dl_pkg.sv
// Shared types, default constants and helpers for the packet handler deadlock reporter.
package packet_handler_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_REPORT  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int unsigned DEF_THRESHOLD = 16;
  localparam int unsigned DEF_TS_W      = 32;
  localparam int unsigned EVT_CNT_W     = 16;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 16'hFFFF;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/packet_handler_dl_persist_cnt.sv
// Persistence counter: load to 1, increment, clear; flags when the next increment hits THRESHOLD.
module packet_handler_dl_persist_cnt #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned THRESHOLD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic clr,
  output logic next_at_thresh_c
);

  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign next_at_thresh_c = ((count + CNT_W'(1)) == THRESH_V);

endmodule

// File: rtl/packet_handler_deadlock_reporter.sv
// Confirms persistent monitor block flags, reports the event once over valid/ready, holds a sticky flag.
// Optional DEADLOCK_RPT_EVENT_COUNT_EN adds a saturating count of delivered reports.
module packet_handler_deadlock_reporter
  import packet_handler_dl_pkg::*;
#(
  parameter int unsigned NUM_MON   = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TS_W      = DEF_TS_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] block_in,
  input  logic               clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_mon_idx,
  output logic [TS_W-1:0]    rpt_timestamp,
  output logic               deadlock_active
`ifdef DEADLOCK_RPT_EVENT_COUNT_EN
  ,
  output logic [EVT_CNT_W-1:0] event_count
`endif
);

  localparam bit DIRECT_RPT = (THRESHOLD == 1);

  state_t           state;
  logic [IDX_W-1:0] cand_idx;
  logic [TS_W-1:0]  ts;

  logic             any_block_c;
  logic [IDX_W-1:0] lowest_idx_c;
  logic             cand_block_c;
  logic             cnt_load_c;
  logic             cnt_inc_c;
  logic             cnt_clr_c;
  logic             hit_c;

  assign any_block_c  = |block_in;
  assign lowest_idx_c = IDX_W'(lowest_set(32'(block_in)));
  assign cand_block_c = block_in[cand_idx];

  assign cnt_load_c = (state == ST_IDLE) && any_block_c;
  assign cnt_inc_c  = (state == ST_CONFIRM) && cand_block_c;
  assign cnt_clr_c  = !(cnt_load_c || cnt_inc_c);

  packet_handler_dl_persist_cnt #(
    .CNT_W     (CNT_W),
    .THRESHOLD (THRESHOLD)
  ) u_persist_cnt (
    .clock            (clock),
    .reset            (reset),
    .load             (cnt_load_c),
    .inc              (cnt_inc_c),
    .clr              (cnt_clr_c),
    .next_at_thresh_c (hit_c)
  );

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      cand_idx        <= '0;
      rpt_valid       <= 1'b0;
      rpt_mon_idx     <= '0;
      rpt_timestamp   <= '0;
      deadlock_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_block_c) begin
            cand_idx <= lowest_idx_c;
            if (DIRECT_RPT) begin
              state           <= ST_REPORT;
              rpt_valid       <= 1'b1;
              deadlock_active <= 1'b1;
              rpt_mon_idx     <= lowest_idx_c;
              rpt_timestamp   <= ts;
            end else begin
              state <= ST_CONFIRM;
            end
          end
        end
        // Only the captured monitor matters; other bits never retarget.
        ST_CONFIRM: begin
          if (!cand_block_c) begin
            state <= ST_IDLE;
          end else if (hit_c) begin
            state           <= ST_REPORT;
            rpt_valid       <= 1'b1;
            deadlock_active <= 1'b1;
            rpt_mon_idx     <= cand_idx;
            rpt_timestamp   <= ts;
          end
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            state     <= ST_HOLD;
            rpt_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (clear) begin
            state           <= ST_IDLE;
            deadlock_active <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DEADLOCK_RPT_EVENT_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      event_count <= '0;
    end else if (rpt_valid && rpt_ready && (event_count != EVT_CNT_MAX)) begin
      event_count <= event_count + EVT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_packet_handler_deadlock_reporter.sv
// Directed plus randomized bench for packet_handler_deadlock_reporter against a behavioural model.
module tb_packet_handler_deadlock_reporter;

  localparam int unsigned NUM_MON   = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned THRESHOLD = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned TS_W      = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_MON-1:0] block_in;
  logic               clear;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [IDX_W-1:0]   rpt_mon_idx;
  logic [TS_W-1:0]    rpt_timestamp;
  logic               deadlock_active;
`ifdef DEADLOCK_RPT_EVENT_COUNT_EN
  logic [15:0]        event_count;
`endif

  packet_handler_deadlock_reporter #(
    .NUM_MON   (NUM_MON),
    .IDX_W     (IDX_W),
    .THRESHOLD (THRESHOLD),
    .CNT_W     (CNT_W),
    .TS_W      (TS_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .block_in        (block_in),
    .clear           (clear),
    .rpt_valid       (rpt_valid),
    .rpt_ready       (rpt_ready),
    .rpt_mon_idx     (rpt_mon_idx),
    .rpt_timestamp   (rpt_timestamp),
    .deadlock_active (deadlock_active)
`ifdef DEADLOCK_RPT_EVENT_COUNT_EN
    ,
    .event_count     (event_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the report fires once a single monitor has been seen high for
  // THRESHOLD consecutive sampled cycles; delivered reports stay sticky until a clear.
  int        m_ts;
  bit        m_valid, m_dl, m_holding, m_watch;
  int        m_idx, m_ts_out, m_cand, m_streak, m_evt;

  function automatic int lowest(input logic [NUM_MON-1:0] b);
    int l = 0;
    for (int i = NUM_MON - 1; i >= 0; i--) if (b[i]) l = i;
    return l;
  endfunction

  task automatic model_edge();
    int ts_now;
    if (reset) begin
      m_ts = 0; m_valid = 0; m_dl = 0; m_holding = 0; m_watch = 0;
      m_idx = 0; m_ts_out = 0; m_cand = 0; m_streak = 0; m_evt = 0;
      return;
    end
    ts_now = m_ts;
    if (m_valid) begin
      if (rpt_ready) begin
        m_valid = 0; m_holding = 1;
        if (m_evt < 65535) m_evt++;
      end
    end else if (m_holding) begin
      if (clear) begin m_holding = 0; m_dl = 0; end
    end else if (!m_watch) begin
      if (block_in != '0) begin
        m_cand = lowest(block_in); m_streak = 1; m_watch = 1;
      end
    end else if (block_in[m_cand]) begin
      m_streak++;
    end else begin
      m_watch = 0; m_streak = 0;
    end
    if (m_watch && m_streak >= int'(THRESHOLD)) begin
      m_watch = 0; m_streak = 0;
      m_valid = 1; m_dl = 1; m_idx = m_cand; m_ts_out = ts_now;
    end
    m_ts = (ts_now + 1) % (1 << TS_W);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rpt_valid"}, 32'(rpt_valid), 32'(m_valid));
    chk({tag, ".deadlock_active"}, 32'(deadlock_active), 32'(m_dl));
    chk({tag, ".rpt_mon_idx"}, 32'(rpt_mon_idx), 32'(m_idx));
    chk({tag, ".rpt_timestamp"}, 32'(rpt_timestamp), 32'(m_ts_out));
`ifdef DEADLOCK_RPT_EVENT_COUNT_EN
    chk({tag, ".event_count"}, 32'(event_count), 32'(m_evt));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  logic [TS_W-1:0] saved_ts;
  logic [IDX_W-1:0] saved_idx;

  initial begin
    reset = 1'b1; block_in = '0; clear = 1'b0; rpt_ready = 1'b0;
    #1;
    step("reset");
    step("reset");
    chk("reset_valid", 32'(rpt_valid), 32'd0);
    chk("reset_ts", 32'(rpt_timestamp), 32'd0);
    reset = 1'b0;

    // Single monitor held: report exactly THRESHOLD cycles after first high sample.
    rpt_ready = 1'b1; block_in = 4'b0100;
    repeat (15) step("a_confirm");
    chk("a_not_yet_valid", 32'(rpt_valid), 32'd0);
    step("a_confirm");
    chk("a_valid", 32'(rpt_valid), 32'd1);
    chk("a_idx", 32'(rpt_mon_idx), 32'd2);
    chk("a_dl", 32'(deadlock_active), 32'd1);
    block_in = '0;
    step("a_handshake");
    chk("a_hold_valid", 32'(rpt_valid), 32'd0);
    chk("a_hold_dl", 32'(deadlock_active), 32'd1);
    clear = 1'b1; step("a_clear"); clear = 1'b0;
    chk("a_cleared", 32'(deadlock_active), 32'd0);

    // Drop on the cycle the count would reach THRESHOLD; clear in IDLE/CONFIRM ignored.
    block_in = 4'b0001; clear = 1'b1;
    repeat (15) step("b_confirm");
    block_in = '0; clear = 1'b0;
    step("b_drop");
    step("b_idle");
    chk("b_no_valid", 32'(rpt_valid), 32'd0);
    chk("b_no_dl", 32'(deadlock_active), 32'd0);

    // Backpressure: fields stable; clear during REPORT ignored.
    rpt_ready = 1'b0; block_in = 4'b1010;
    repeat (16) step("c_confirm");
    chk("c_valid", 32'(rpt_valid), 32'd1);
    chk("c_idx", 32'(rpt_mon_idx), 32'd1);
    saved_ts = rpt_timestamp; saved_idx = rpt_mon_idx;
    for (int i = 0; i < 5; i++) begin
      clear = (i == 2);
      step("c_stall");
      chk("c_stall_valid", 32'(rpt_valid), 32'd1);
      chk("c_stall_ts", 32'(rpt_timestamp), 32'(saved_ts));
      chk("c_stall_idx", 32'(rpt_mon_idx), 32'(saved_idx));
    end
    clear = 1'b1; rpt_ready = 1'b1;
    step("c_accept_with_clear");
    clear = 1'b0; rpt_ready = 1'b0;
    chk("c_in_hold", 32'(deadlock_active), 32'd1);
    repeat (3) step("c_hold");
    chk("c_still_hold", 32'(deadlock_active), 32'd1);
    clear = 1'b1; step("c_clear_block_high"); clear = 1'b0;
    chk("c_cleared", 32'(deadlock_active), 32'd0);
    step("c_redetect");
    block_in = '0;
    step("c_idle");

    // Timestamp wrap: first sample at ts=1, confirmation at ts=(1+15)%16=0.
    for (int i = 0; i < 20 && m_ts != 1; i++) step("d_align");
    block_in = 4'b0001;
    repeat (16) step("d_confirm");
    chk("d_valid", 32'(rpt_valid), 32'd1);
    chk("d_wrap_ts", 32'(rpt_timestamp), 32'd0);
    reset = 1'b1; step("d_reset_in_report"); reset = 1'b0;
    chk("d_reset_valid", 32'(rpt_valid), 32'd0);
    chk("d_reset_dl", 32'(deadlock_active), 32'd0);
    chk("d_reset_idx", 32'(rpt_mon_idx), 32'd0);
    block_in = '0;

    // Randomized segments of held patterns with random ready/clear and rare reset.
    for (int s = 0; s < 60; s++) begin
      logic [NUM_MON-1:0] pat;
      int dur;
      pat = ($urandom_range(0, 3) == 0) ? '0 : NUM_MON'($urandom_range(1, 15));
      dur = $urandom_range(1, 24);
      for (int c = 0; c < dur; c++) begin
        block_in  = ($urandom_range(0, 40) == 0) ? '0 : pat;
        rpt_ready = 1'($urandom_range(0, 1));
        clear     = ($urandom_range(0, 7) == 0);
        reset     = ($urandom_range(0, 300) == 0);
        step("rand");
      end
    end
    reset = 1'b0; clear = 1'b0;

`ifdef DEADLOCK_RPT_EVENT_COUNT_EN
    begin
      int base;
      base = m_evt;
      rpt_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
        block_in = 4'b1000;
        repeat (17) step("e_cycle");
        block_in = '0;
        clear = 1'b1; step("e_clear"); clear = 1'b0;
        step("e_idle");
      end
      chk("e_count3", 32'(event_count), 32'(base + 3));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_handler_deadlock_reporter.md
Name: packet_handler_deadlock_reporter

Overview:
Consumer of the per-instance deadlock monitor `block` outputs in the packet handler dataflow region. It confirms that a block indication persists for a programmable number of cycles, then latches the event. It delivers one report (monitor index plus timestamp) over a valid/ready status channel and holds a sticky deadlock flag until software clears it.

Parameters:
NUM_MON, 4, number of monitor `block` inputs (1..32)
IDX_W, 2, width of monitor index; must equal max(1, clog2(NUM_MON))
THRESHOLD, 16, consecutive cycles a `block` must stay high to confirm (>=1)
CNT_W, 8, persistence counter width; must satisfy 2^CNT_W > THRESHOLD
TS_W, 32, free-running timestamp width

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
block_in  in  NUM_MON  per-monitor block flags, one per monitor instance
clear  in  1  single-cycle pulse; releases the sticky deadlock state
rpt_valid  out  1  report available
rpt_ready  in  1  sink accepts report
rpt_mon_idx  out  IDX_W  index of confirmed blocking monitor
rpt_timestamp  out  TS_W  timestamp counter value at confirmation
deadlock_active  out  1  sticky deadlock flag

Behaviour:
- Reset: state=IDLE; rpt_valid=0, rpt_mon_idx=0, rpt_timestamp=0, deadlock_active=0; persistence counter=0; timestamp counter=0.
- Timestamp counter increments every cycle, wraps from 2^TS_W-1 to 0, and is never held.
- FSM states IDLE, CONFIRM, REPORT, HOLD.
- IDLE: if any block_in bit is 1, capture the lowest set index into cand_idx, set count=1, and go to CONFIRM. If THRESHOLD==1, go directly to REPORT instead and capture the timestamp.
- CONFIRM:
  - If block_in[cand_idx]==0: go to IDLE, count=0. Other bits are ignored and do not retarget.
  - Else count+1. When the incremented count equals THRESHOLD: go to REPORT, latch rpt_mon_idx=cand_idx, and latch rpt_timestamp=the current timestamp value.
  - Total latency from the first block_in high cycle to rpt_valid=1 is THRESHOLD cycles.
- REPORT:
  - rpt_valid=1, with rpt_mon_idx and rpt_timestamp held stable until the handshake.
  - On rpt_valid&rpt_ready, go to HOLD; rpt_valid falls next cycle.
  - block_in and clear are ignored in this state, so the report is always delivered.
- HOLD: deadlock_active=1 and rpt_* keep their last values. On clear==1, go to IDLE and deadlock_active=0 next cycle, regardless of block_in.
- deadlock_active rises in the same cycle rpt_valid rises (registered on entry to REPORT) and stays high through REPORT and HOLD.
- Boundaries:
  - block dropping on the cycle the count would reach THRESHOLD: no report, return to IDLE.
  - clear in IDLE or CONFIRM: no effect.
  - clear with rpt_ready in REPORT: handshake completes, clear is ignored, state=HOLD.
  - clear in HOLD while block_in is still high: go to IDLE, which can re-detect on the next cycle.
  - reset mid-REPORT: rpt_valid drops the next cycle with no partial report.
- The counter never exceeds THRESHOLD; no overflow is possible given the CNT_W constraint.

Optional Feature:
Macro DEADLOCK_RPT_EVENT_COUNT_EN.
- Defined: adds output event_count (16 bits).
  - Reset value 0.
  - Increments by 1 on each REPORT handshake; saturates at 0xFFFF.
  - Unaffected by clear.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package packet_handler_dl_pkg holds:
  - the state enum typedef (IDLE/CONFIRM/REPORT/HOLD);
  - default constants for THRESHOLD, TS_W, and the event-counter width/saturation value;
  - a function returning the lowest set bit index of a vector.
- One natural sub-module: packet_handler_dl_persist_cnt, the persistence counter with load/increment/clear and an equality-to-THRESHOLD flag.

Test Plan:
- block_in=4'b0100 held 16 cycles (THRESHOLD=16), rpt_ready=1 -> rpt_valid high exactly 16 cycles after the first high sample, rpt_mon_idx=2, rpt_timestamp equals the counter value at that cycle.
- block_in=4'b0001 high 15 cycles then 0 -> no rpt_valid, deadlock_active=0, FSM back to IDLE.
- block_in=4'b1010 held, rpt_ready=0 for 5 cycles after valid -> rpt_valid and fields stable all 5 cycles; after ready, deadlock_active stays 1 until a clear pulse, then 0 the next cycle.
- clear pulsed during REPORT with rpt_ready=0 -> ignored; report still delivered; HOLD entered.
- Timestamp preloaded near wrap (TS_W=4, event at count 15 then 0) -> rpt_timestamp reflects the wrapped value; reset asserted during REPORT -> all outputs 0 the next cycle.
- With DEADLOCK_RPT_EVENT_COUNT_EN defined: three confirm/report/clear cycles -> event_count=3; without the macro, the port is absent and the bench compiles.
